// File: rtl/elink_byte_aligner.sv
// Byte aligner behind the 2-bit/clk SIPO: hunts SYNC_CHAR at bit offset 0/1, then emits one byte per 4 clks.
// Latency: byte registered on the clk after its slot; no backpressure, the bitstream is live.
module elink_byte_aligner #(
   parameter logic [7:0] SYNC_CHAR  = 8'hBC,
   parameter int         LOCK_COUNT = 4,
   parameter int         WDOG_BYTES = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] window_i,
   input  logic        relock_i,
   output logic [7:0]  byte_o,
   output logic        byte_valid_o,
   output logic        is_sync_o,
   output logic        locked_o,
   output logic        offset_o,
   output logic        lock_loss_o
);

   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int WW = $clog2(WDOG_BYTES);
   localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
   localparam logic [WW-1:0] WDOG_LAST  = WW'(WDOG_BYTES - 1);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t        state;
   logic [1:0]    phase_r;
   logic          off_r;
   logic [MW-1:0] match_cnt;
   logic [WW-1:0] wdog_cnt;

   logic [7:0] cand0;
   logic [7:0] cand1;
   logic [7:0] slot_byte;
   logic       hit0;
   logic       hit1;
   logic       slot;
   logic       slot_sync;

   // Upper window bits are SIPO look-ahead that this stage never needs.
   logic unused_window;
   assign unused_window = ^window_i[11:9];

   always_comb begin
      cand0     = window_i[7:0];
      cand1     = window_i[8:1];
      hit0      = (cand0 == SYNC_CHAR);
      hit1      = (cand1 == SYNC_CHAR);
      slot_byte = off_r ? cand1 : cand0;
      slot      = (phase_r == 2'd3);
      slot_sync = (slot_byte == SYNC_CHAR);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= HUNT;
         phase_r      <= 2'd0;
         off_r        <= 1'b0;
         match_cnt    <= '0;
         wdog_cnt     <= '0;
         byte_o       <= 8'd0;
         byte_valid_o <= 1'b0;
         is_sync_o    <= 1'b0;
         locked_o     <= 1'b0;
         offset_o     <= 1'b0;
         lock_loss_o  <= 1'b0;
      end else begin
         byte_valid_o <= 1'b0;
         lock_loss_o  <= 1'b0;
         if (relock_i) begin
            state     <= HUNT;
            phase_r   <= 2'd0;
            match_cnt <= '0;
            wdog_cnt  <= '0;
            locked_o  <= 1'b0;
            offset_o  <= 1'b0;
            is_sync_o <= 1'b0;
         end else begin
            case (state)
               HUNT: begin
                  phase_r <= 2'd0;
                  if (hit0 || hit1) begin
                     // Offset 0 wins a tie.
                     off_r     <= !hit0;
                     match_cnt <= MW'(1);
                     wdog_cnt  <= '0;
                     if (LOCK_COUNT == 1) begin
                        state    <= LOCKED;
                        locked_o <= 1'b1;
                        offset_o <= !hit0;
                     end else begin
                        state <= VERIFY;
                     end
                  end
               end

               VERIFY: begin
                  phase_r <= phase_r + 2'd1;
                  if (slot) begin
                     if (slot_sync) begin
                        match_cnt <= match_cnt + MW'(1);
                        if (match_cnt == MATCH_LAST) begin
                           state    <= LOCKED;
                           locked_o <= 1'b1;
                           offset_o <= off_r;
                           wdog_cnt <= '0;
                        end
                     end else begin
                        state     <= HUNT;
                        match_cnt <= '0;
                        phase_r   <= 2'd0;
                     end
                  end
               end

               LOCKED: begin
                  phase_r <= phase_r + 2'd1;
                  if (slot) begin
                     byte_o       <= slot_byte;
                     byte_valid_o <= 1'b1;
                     is_sync_o    <= slot_sync;
                     if (slot_sync) begin
                        wdog_cnt <= '0;
                     end else if (wdog_cnt == WDOG_LAST) begin
                        // The byte of the expiring slot still goes out alongside the loss pulse.
                        state       <= HUNT;
                        lock_loss_o <= 1'b1;
                        locked_o    <= 1'b0;
                        offset_o    <= 1'b0;
                        wdog_cnt    <= '0;
                        match_cnt   <= '0;
                        phase_r     <= 2'd0;
                     end else begin
                        wdog_cnt <= wdog_cnt + WW'(1);
                     end
                  end
               end

               default: begin
                  state     <= HUNT;
                  phase_r   <= 2'd0;
                  match_cnt <= '0;
                  wdog_cnt  <= '0;
                  locked_o  <= 1'b0;
                  offset_o  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_elink_byte_aligner.sv
// Directed bench: a bit-level SIPO model feeds the aligner; strobes and lock events are logged per clk.
module tb_elink_byte_aligner;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] window = 12'd0;
   logic        relock = 1'b0;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        is_sync;
   logic        locked;
   logic        offset;
   logic        lock_loss;

   elink_byte_aligner #(
      .SYNC_CHAR (8'hBC),
      .LOCK_COUNT(4),
      .WDOG_BYTES(8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .window_i    (window),
      .relock_i    (relock),
      .byte_o      (byte_out),
      .byte_valid_o(byte_valid),
      .is_sync_o   (is_sync),
      .locked_o    (locked),
      .offset_o    (offset),
      .lock_loss_o (lock_loss)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   bitq[$];
   int   s_cyc[$];
   logic [7:0] s_byte[$];
   logic s_sync[$];
   int   lock_rises = 0;
   int   lock_cyc = -1;
   int   loss_cnt = 0;
   int   loss_cyc = -1;
   logic loss_locked = 1'b1;
   logic prev_locked = 1'b0;
   bit   locked_seen = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] sb(input int i);
      if (i < s_byte.size()) return s_byte[i];
      return 8'hxx;
   endfunction

   function automatic logic ss(input int i);
      if (i < s_sync.size()) return s_sync[i];
      return 1'bx;
   endfunction

   function automatic int sc(input int i);
      if (i < s_cyc.size()) return s_cyc[i];
      return -1000;
   endfunction

   // One clk: sample outputs after the edge, then shift the next bit pair into the window.
   task automatic tick();
      logic b0;
      logic b1;
      @(posedge clk);
      #1;
      cyc++;
      if (byte_valid === 1'b1) begin
         s_cyc.push_back(cyc);
         s_byte.push_back(byte_out);
         s_sync.push_back(is_sync);
      end
      if (lock_loss === 1'b1) begin
         loss_cnt++;
         loss_cyc = cyc;
         loss_locked = locked;
      end
      if (locked === 1'b1 && prev_locked !== 1'b1) begin
         lock_rises++;
         lock_cyc = cyc;
      end
      if (locked === 1'b1) locked_seen = 1'b1;
      prev_locked = locked;
      b0 = (bitq.size() > 0) ? bitq.pop_front() : 1'b0;
      b1 = (bitq.size() > 0) ? bitq.pop_front() : 1'b0;
      window = {b1, b0, window[11:2]};
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b, input int n);
      repeat (n) begin
         for (int i = 0; i < 8; i++) bitq.push_back(b[i]);
      end
   endtask

   task automatic clear_log();
      s_cyc.delete();
      s_byte.delete();
      s_sync.delete();
      lock_rises = 0;
      lock_cyc = -1;
      loss_cnt = 0;
      loss_cyc = -1;
      loss_locked = 1'b1;
      locked_seen = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      relock = 1'b0;
      bitq.delete();
      window = 12'd0;
      run(n);
      rst = 1'b1;
      clear_log();
   endtask

   task automatic wait_lock(input string tag, input int budget);
      int k;
      k = 0;
      while (locked !== 1'b1 && k < budget) begin
         tick();
         k++;
      end
      check(tag, locked, 1'b1);
   endtask

   initial begin
      // T1: reset with an idle window
      rst = 1'b0;
      window = 12'd0;
      run(8);
      check("T1_byte", byte_out, 8'h00);
      check("T1_valid", byte_valid, 1'b0);
      check("T1_sync", is_sync, 1'b0);
      check("T1_locked", locked, 1'b0);
      check("T1_offset", offset, 1'b0);
      check("T1_loss", lock_loss, 1'b0);
      rst = 1'b1;
      clear_log();
      run(12);
      check("T1_never_locked", locked_seen, 1'b0);
      check("T1_no_strobes", s_byte.size(), 0);

      // T2: even alignment
      do_reset(3);
      send_byte(8'hBC, 4);
      send_byte(8'hA5, 1);
      send_byte(8'hBC, 2);
      wait_lock("T2_lock", 60);
      check("T2_offset", offset, 1'b0);
      check("T2_no_strobe_at_lock", s_byte.size(), 0);
      run(12);
      check("T2_byte0", sb(0), 8'hA5);
      check("T2_sync0", ss(0), 1'b0);
      check("T2_byte1", sb(1), 8'hBC);
      check("T2_sync1", ss(1), 1'b1);
      check("T2_first_after_lock", sc(0) - lock_cyc, 4);
      check("T2_spacing", sc(1) - sc(0), 4);

      // T3: stream slipped by one bit
      do_reset(3);
      bitq.push_back(1'b0);
      send_byte(8'hBC, 4);
      send_byte(8'hA5, 1);
      send_byte(8'hBC, 2);
      wait_lock("T3_lock", 60);
      check("T3_offset", offset, 1'b1);
      run(8);
      check("T3_byte0", sb(0), 8'hA5);

      // T4: broken verify run falls back to hunting, then relocks
      do_reset(3);
      send_byte(8'hBC, 3);
      send_byte(8'h00, 1);
      send_byte(8'hBC, 4);
      send_byte(8'hA5, 1);
      run(24);
      check("T4_no_early_lock", locked_seen, 1'b0);
      wait_lock("T4_relock", 60);
      check("T4_lock_rises", lock_rises, 1);
      run(8);
      check("T4_byte0", sb(0), 8'hA5);

      // T5: watchdog, with one sync byte restarting the count
      do_reset(3);
      send_byte(8'hBC, 4);
      send_byte(8'h11, 3);
      send_byte(8'hBC, 1);
      send_byte(8'h11, 8);
      wait_lock("T5_lock", 60);
      run(60);
      check("T5_loss_count", loss_cnt, 1);
      check("T5_strobes", s_byte.size(), 12);
      check("T5_sync_byte", sb(3), 8'hBC);
      check("T5_sync_flag", ss(3), 1'b1);
      check("T5_last_byte", sb(11), 8'h11);
      check("T5_last_flag", ss(11), 1'b0);
      check("T5_loss_with_last", sc(11), loss_cyc);
      check("T5_unlocked_at_loss", loss_locked, 1'b0);
      check("T5_still_unlocked", locked, 1'b0);

      // T6: relock request at a slot, then reset, both mid-LOCKED
      do_reset(3);
      send_byte(8'hBC, 40);
      wait_lock("T6_lock", 60);
      run(9);
      while (cyc < sc(s_cyc.size() - 1) + 3) tick();
      begin
         int n_before;
         n_before = s_byte.size();
         relock = 1'b1;
         tick();
         relock = 1'b0;
         check("T6_relock_locked", locked, 1'b0);
         check("T6_relock_valid", byte_valid, 1'b0);
         check("T6_relock_loss", lock_loss, 1'b0);
         check("T6_relock_no_byte", s_byte.size(), n_before);
      end
      wait_lock("T6_rehunt", 60);
      check("T6_rehunt_offset", offset, 1'b0);
      run(6);
      rst = 1'b0;
      tick();
      check("T6_rst_locked", locked, 1'b0);
      check("T6_rst_valid", byte_valid, 1'b0);
      check("T6_rst_loss", lock_loss, 1'b0);
      check("T6_rst_byte", byte_out, 8'h00);
      rst = 1'b1;
      wait_lock("T6_after_rst", 60);
      check("T6_loss_never", loss_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
